// File: rtl/noc_pkt_arbmux.sv
// noc_pkt_arbmux: N:1 packet arbiter (round-robin or fixed priority) feeding a first-word-fall-through FIFO.
// A granted multi-flit packet holds the lock until its last flit, so packets leave the FIFO contiguous.
module noc_pkt_arbmux #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 4,
  parameter int DEPTH      = 4,
  parameter int MODE       = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
  input  logic [CHANNELS-1:0]                  in_last,
  input  logic [CHANNELS-1:0]                  in_valid,
  output logic [CHANNELS-1:0]                  in_ready,
  output logic [FLIT_WIDTH-1:0]                out_flit,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy,
  output logic [$clog2(CHANNELS)-1:0]          grant_id,
  output logic                                 locked
);
  localparam int IW = $clog2(CHANNELS);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   rr_ptr, rr_next, grant_next, winner, sel, scan_idx;
  logic [IW:0]     scan_sum;
  logic            any_valid, full, wr_en, rd_en;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [FLIT_WIDTH:0] mem [DEPTH];

  // Scan order starts at rr_ptr in round-robin mode; the downward loop lets the nearest valid port win.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = CHANNELS-1; i >= 0; i--) begin
      scan_sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (scan_sum >= (IW+1)'(CHANNELS))
        scan_sum = scan_sum - (IW+1)'(CHANNELS);
      scan_idx = (MODE == 0) ? scan_sum[IW-1:0] : IW'(i);
      if (in_valid[scan_idx]) begin
        winner    = scan_idx;
        any_valid = 1'b1;
      end
    end
  end

  assign locked = (state == LOCKED);
  assign sel    = locked ? grant_id : winner;
  assign full   = (occupancy == OW'(DEPTH));

  always_comb begin
    in_ready = '0;
    if (!rst && !full && (locked || any_valid))
      in_ready[sel] = 1'b1;
  end

  assign wr_en = in_valid[sel] & in_ready[sel];
  assign rd_en = out_valid & out_ready;

  always_comb begin
    state_next = state;
    grant_next = grant_id;
    rr_next    = rr_ptr;
    if (wr_en) begin
      if (in_last[sel]) begin
        state_next = IDLE;
        grant_next = '0;
        if (MODE == 0)
          rr_next = (sel == IW'(CHANNELS-1)) ? '0 : sel + IW'(1);
      end else begin
        state_next = LOCKED;
        grant_next = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_next;
      grant_id <= grant_next;
      rr_ptr   <= rr_next;
    end
  end

  // Storage is never reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {in_last[sel], in_flit[sel]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PW'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !rd_en)
        occupancy <= occupancy + OW'(1);
      else if (rd_en && !wr_en)
        occupancy <= occupancy - OW'(1);
    end
  end

  assign out_valid            = (occupancy != '0);
  assign {out_last, out_flit} = mem[rd_ptr];

endmodule
